unified_mem_arbiter: RTL

Shares one single-port memory between the pipeline's instruction-fetch port and data-memory port. One transaction is in flight at a time, with a bounded-fairness priority scheme. The block drives the freeze controls the hazard logic uses when memory is busy. It sits between the core (fetch and memory stages) and the memory bus.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/unified_mem_arbiter_fair_pick.sv | 43 ++++
 rtl/unified_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, requester ids
// and the default fairness bound.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        SRC_IF,
        SRC_DM
    } arb_src_t;

    localparam int DEFAULT_MAX_DATA_BURST = 4;

endpackage

// File: rtl/unified_mem_arbiter_fair_pick.sv
// Winner selection between fetch and data requests. Data normally wins, but a
// pending fetch is forced through after MAX_DATA_BURST consecutive data grants.
module arb_fair_pick
    import riscv_mem_pkg::*;
#(
    parameter int MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     if_req,
    input  logic     dm_req,
    input  logic     grant,
    output arb_src_t winner,
    output logic     winner_valid
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    logic [CW-1:0] burst_cnt;
    logic          at_limit;

    assign at_limit = (burst_cnt == CW'(MAX_DATA_BURST));

    always_comb begin
        winner_valid = if_req | dm_req;
        winner       = (dm_req && !(if_req && at_limit)) ? SRC_DM : SRC_IF;
    end

    // grant is the IDLE-state sampling strobe; the counter only tracks data
    // grants that starved a waiting fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (grant) begin
            if (!if_req || winner == SRC_IF) begin
                burst_cnt <= '0;
            end else if (!at_limit) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch and data access, one
// transaction in flight, with pipeline freeze outputs for the hazard unit.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int AW             = 32,
    parameter int MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [XLEN/8-1:0] dm_wstrb,
    input  logic [AW-1:0]     dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SW = XLEN / 8;

    arb_state_t        state_reg, state_next;
    arb_src_t          src_reg;
    logic              we_reg;
    logic [SW-1:0]     wstrb_reg;
    logic [AW-1:0]     addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [XLEN-1:0]   if_rdata_reg;
    logic [XLEN-1:0]   dm_rdata_reg;

    arb_src_t          winner;
    logic              winner_valid;
    logic              grant;
    logic              capture;

    assign grant = (state_reg == IDLE);

    arb_fair_pick #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .grant       (grant),
        .winner      (winner),
        .winner_valid(winner_valid)
    );

    // A response is only accepted once the bus has granted this transaction.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: if (winner_valid) state_next = REQ;
            REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_reg   <= SRC_IF;
            we_reg    <= 1'b0;
            wstrb_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (grant && winner_valid) begin
            src_reg <= winner;
            if (winner == SRC_DM) begin
                we_reg    <= dm_we;
                wstrb_reg <= dm_wstrb;
                addr_reg  <= dm_addr;
                wdata_reg <= dm_wdata;
            end else begin
                we_reg    <= 1'b0;
                wstrb_reg <= '0;
                addr_reg  <= if_addr;
                wdata_reg <= '0;
            end
        end
    end

    // Store acknowledgements carry no data, so dm_rdata keeps the last load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else if (capture) begin
            if (src_reg == SRC_IF) begin
                if_rdata_reg <= mem_rdata;
            end else if (!we_reg) begin
                dm_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_reg == REQ);
    assign mem_we    = we_reg;
    assign mem_wstrb = wstrb_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    assign if_valid  = (state_reg == DONE) && (src_reg == SRC_IF);
    assign dm_valid  = (state_reg == DONE) && (src_reg == SRC_DM);
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule
